// File: rtl/dpram_arb_pkg.sv
// Shared defaults and constants for the dual-client RAM arbiter.
// Client indices double as bit positions in the request/grant vectors.
package dpram_arb_pkg;

    localparam int ADDR_SIZE_DEF = 4;
    localparam int DATA_SIZE_DEF = 8;
    localparam int DEPTH_DEF     = 1 << ADDR_SIZE_DEF;

    localparam int CLIENT_0 = 0;
    localparam int CLIENT_1 = 1;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Tag travelling with each granted read through the two-stage return pipe.
    typedef struct packed {
        logic valid;
        logic client;
        logic bypass;
    } rd_tag_t;

endpackage

// File: rtl/dpram_arbiter_if.sv
// Client request/response and RAM-side signals of the arbiter.
// The slave modport is the arbiter; the master modport is clients plus RAM.
interface dpram_arbiter_if
    import dpram_arb_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF
) ();

    logic                 c0_req, c1_req;
    logic                 c0_wr, c1_wr;
    logic [ADDR_SIZE-1:0] c0_addr, c1_addr;
    logic [DATA_SIZE-1:0] c0_wdata, c1_wdata;
    logic                 c0_gnt, c1_gnt;
    logic                 c0_rvalid, c1_rvalid;
    logic [DATA_SIZE-1:0] c0_rdata, c1_rdata;

    logic                 ram_cs, ram_we, ram_re, ram_oe;
    logic [ADDR_SIZE-1:0] ram_wr_address, ram_rd_address;
    logic [DATA_SIZE-1:0] ram_data_in;
    logic [DATA_SIZE-1:0] ram_data_out;

    modport slave (
        input  c0_req, c0_wr, c0_addr, c0_wdata,
        input  c1_req, c1_wr, c1_addr, c1_wdata,
        output c0_gnt, c0_rvalid, c0_rdata,
        output c1_gnt, c1_rvalid, c1_rdata,
        output ram_cs, ram_we, ram_re, ram_oe,
        output ram_wr_address, ram_rd_address, ram_data_in,
        input  ram_data_out
    );

    modport master (
        output c0_req, c0_wr, c0_addr, c0_wdata,
        output c1_req, c1_wr, c1_addr, c1_wdata,
        input  c0_gnt, c0_rvalid, c0_rdata,
        input  c1_gnt, c1_rvalid, c1_rdata,
        input  ram_cs, ram_we, ram_re, ram_oe,
        input  ram_wr_address, ram_rd_address, ram_data_in,
        output ram_data_out
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the pointed-to client wins and
// the pointer moves to the loser; a lone request never moves the pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                gnt_o = ptr_q ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end
            default: gnt_o = 2'b00;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Arbitrates two clients onto the separate write and read ports of a
// synchronous dual-port RAM, with write-first bypass on same-cycle collisions.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input logic            clk,
    input logic            rst_n,
    dpram_arbiter_if.slave bus
);

    if (DEPTH != (1 << ADDR_SIZE)) begin : g_bad_depth
        $error("DEPTH must equal 2**ADDR_SIZE");
    end

    logic [1:0]           wr_req, rd_req, wr_gnt, rd_gnt;
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
    logic [DATA_SIZE-1:0] wr_data, rd_word;
    logic                 bypass, c0_rvalid, c1_rvalid;
    rd_tag_t              rd_tag_d, rd_s1_q, rd_s2_q;

    logic                 ram_cs_q, ram_we_q, ram_re_q;
    logic [ADDR_SIZE-1:0] ram_wr_address_q, ram_rd_address_q;
    logic [DATA_SIZE-1:0] ram_data_in_q;
    logic [DATA_SIZE-1:0] byp_s1_q, byp_s2_q, c0_rdata_q, c1_rdata_q;

    assign wr_req = {bus.c1_req & (bus.c1_wr == OP_WRITE), bus.c0_req & (bus.c0_wr == OP_WRITE)};
    assign rd_req = {bus.c1_req & (bus.c1_wr == OP_READ),  bus.c0_req & (bus.c0_wr == OP_READ)};

    rr_arb2 u_wr_arb (.clk(clk), .rst_n(rst_n), .req_i(wr_req), .gnt_o(wr_gnt));
    rr_arb2 u_rd_arb (.clk(clk), .rst_n(rst_n), .req_i(rd_req), .gnt_o(rd_gnt));

    assign bus.c0_gnt = wr_gnt[CLIENT_0] | rd_gnt[CLIENT_0];
    assign bus.c1_gnt = wr_gnt[CLIENT_1] | rd_gnt[CLIENT_1];

    assign wr_addr = wr_gnt[CLIENT_1] ? bus.c1_addr  : bus.c0_addr;
    assign wr_data = wr_gnt[CLIENT_1] ? bus.c1_wdata : bus.c0_wdata;
    assign rd_addr = rd_gnt[CLIENT_1] ? bus.c1_addr  : bus.c0_addr;

    // The RAM returns pre-write data on a same-cycle collision, so the write data rides along instead.
    assign bypass   = (|wr_gnt) & (|rd_gnt) & (wr_addr == rd_addr);
    assign rd_tag_d = '{valid: |rd_gnt, client: rd_gnt[CLIENT_1], bypass: bypass};

    // NOTE: the data pipeline and hold registers are reset too, because rdata must read as zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_cs_q         <= 1'b0;
            ram_we_q         <= 1'b0;
            ram_re_q         <= 1'b0;
            ram_wr_address_q <= '0;
            ram_rd_address_q <= '0;
            ram_data_in_q    <= '0;
            rd_s1_q          <= '0;
            rd_s2_q          <= '0;
            byp_s1_q         <= '0;
            byp_s2_q         <= '0;
            c0_rdata_q       <= '0;
            c1_rdata_q       <= '0;
        end else begin
            ram_cs_q <= (|wr_gnt) | (|rd_gnt);
            ram_we_q <= |wr_gnt;
            ram_re_q <= |rd_gnt;
            if (|wr_gnt) begin
                ram_wr_address_q <= wr_addr;
                ram_data_in_q    <= wr_data;
            end
            if (|rd_gnt) ram_rd_address_q <= rd_addr;
            rd_s1_q  <= rd_tag_d;
            byp_s1_q <= wr_data;
            rd_s2_q  <= rd_s1_q;
            byp_s2_q <= byp_s1_q;
            if (c0_rvalid) c0_rdata_q <= rd_word;
            if (c1_rvalid) c1_rdata_q <= rd_word;
        end
    end

    // RAM data only exists in the return cycle, so it is passed through then and held afterwards.
    assign rd_word   = rd_s2_q.bypass ? byp_s2_q : bus.ram_data_out;
    assign c0_rvalid = rd_s2_q.valid & ~rd_s2_q.client;
    assign c1_rvalid = rd_s2_q.valid &  rd_s2_q.client;

    assign bus.c0_rvalid = c0_rvalid;
    assign bus.c1_rvalid = c1_rvalid;
    assign bus.c0_rdata  = c0_rvalid ? rd_word : c0_rdata_q;
    assign bus.c1_rdata  = c1_rvalid ? rd_word : c1_rdata_q;

    assign bus.ram_cs         = ram_cs_q;
    assign bus.ram_we         = ram_we_q;
    assign bus.ram_re         = ram_re_q;
    assign bus.ram_oe         = ram_re_q;
    assign bus.ram_wr_address = ram_wr_address_q;
    assign bus.ram_rd_address = ram_rd_address_q;
    assign bus.ram_data_in    = ram_data_in_q;

endmodule

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 4, RAM address width.
REQ-002 Parameter DATA_SIZE, default 8, RAM data width.
REQ-003 Parameter DEPTH, default 16, RAM word count (2**ADDR_SIZE).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cN_req  in  1  client N (N=0,1) request; held until cN_gnt.
REQ-007 cN_wr  in  1  client N op: 1=write, 0=read.
REQ-008 cN_addr  in  ADDR_SIZE  client N address.
REQ-009 cN_wdata  in  DATA_SIZE  client N write data.
REQ-010 cN_gnt  out  1  client N request accepted this cycle (combinational).
REQ-011 cN_rvalid  out  1  client N read data valid, one-cycle pulse.
REQ-012 cN_rdata  out  DATA_SIZE  client N read data.
REQ-013 ram_cs, ram_we, ram_re, ram_oe  out  1 each  RAM controls, registered.
REQ-014 ram_wr_address, ram_rd_address  out  ADDR_SIZE  RAM addresses, registered.
REQ-015 ram_data_in  out  DATA_SIZE  RAM write data, registered.
REQ-016 ram_data_out  in  DATA_SIZE  RAM read data, valid one cycle after ram_re/ram_oe cycle.

Function
REQ-017 Write port and read port are arbitrated independently; one write and one read granted per cycle max.
REQ-018 One client writing, other reading, same cycle: both granted.
REQ-019 Both writing or both reading: 2-way round-robin per port; pointer reset to client 0; after a contested grant pointer moves to the loser; uncontested grants leave pointer unchanged.
REQ-020 Grant in cycle T -> ram_cs/ram_we (write) or ram_cs/ram_re/ram_oe (read) high in T+1 with granted address/data; deasserted in T+1 when no grant in T.
REQ-021 Read granted in T -> cN_rvalid pulse with cN_rdata in T+2, to the granted client only.
REQ-022 Same-cycle write and read grant to equal addresses: cN_rdata in T+2 = granted write data (write-first bypass), not ram_data_out.
REQ-023 Write granted T, read same address granted T+1: no bypass; RAM returns new data.
REQ-024 Back-to-back reads sustained: one rvalid per cycle, order preserved.
REQ-025 cN_rdata holds last value when cN_rvalid low.
REQ-026 Address wrap: 4'hF and 4'h0 treated as ordinary addresses; no boundary special-casing.
REQ-027 cN_req low: cN_gnt low irrespective of other inputs.

Reset
REQ-028 rst_n low: all ram_* outputs, cN_rvalid, cN_rdata, pipeline valids and both RR pointers clear to 0 immediately.
REQ-029 Reset mid-operation: in-flight reads dropped, no rvalid after release; in-flight write not issued if not yet driven to RAM.
REQ-030 First grant possible in first cycle after rst_n release.

Structure
REQ-031 Package dpram_arb_pkg holds ADDR_SIZE, DATA_SIZE, DEPTH defaults and client-index/op constants.
REQ-032 Sub-module rr_arb2 (2-way round-robin, req[1:0] -> gnt[1:0], pointer state) instantiated twice (write port, read port).

Verification
REQ-033 c0 write addr 3 data 8'hA5 in T; c1 read addr 3 in T+3 -> ram_we high T+1; c1_rvalid T+5 with 8'hA5.
REQ-034 c0 and c1 both write (addr 1/8'h11, addr 2/8'h22) held 2 cycles -> c0_gnt first, c1_gnt next cycle; repeat contest -> c1 wins.
REQ-035 c0 write addr 5 8'h3C, c1 read addr 5 same cycle -> both gnt; c1_rvalid T+2 with 8'h3C (bypass).
REQ-036 c0 reads addr 0..15 back-to-back after fill with data=addr -> 16 consecutive rvalids, data 0..15, incl. 15->0 wrap.
REQ-037 Read granted T, rst_n low in T+1 -> no c*_rvalid; all ram_* zero during reset.
